// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM-to-WB pipeline: slice record, depth limit and zero register.
package mem_wb_pipe_pkg;
  localparam int STAGES_MAX = 4;
  localparam int REG_ZERO   = 0;
  localparam int DW_DEF     = 32;
  localparam int AW_DEF     = 5;

  typedef struct packed {
    logic              valid;
    logic              rfwe;
    logic              sel;
    logic [DW_DEF-1:0] dmout;
    logic [DW_DEF-1:0] aluout;
    logic [AW_DEF-1:0] rtd;
  } mem_wb_slice_t;
endpackage

// File: rtl/mem_wb_pipe_slice.sv
// One MEM/WB register slice: async active-low clear, hold, and bubble (all-zero) load.
module mem_wb_slice #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          load_i,
  input  logic          bubble_i,
  input  logic          valid_i,
  input  logic          rfwe_i,
  input  logic          sel_i,
  input  logic [DW-1:0] dm_i,
  input  logic [DW-1:0] alu_i,
  input  logic [AW-1:0] rtd_i,
  output logic          valid_o,
  output logic          rfwe_o,
  output logic          sel_o,
  output logic [DW-1:0] dm_o,
  output logic [DW-1:0] alu_o,
  output logic [AW-1:0] rtd_o
);
  localparam int SW = 3 + 2 * DW + AW;

  logic [SW-1:0] slice_d, slice_q;

  // Bubble takes precedence over both load and hold.
  always_comb begin
    slice_d = slice_q;
    if (bubble_i) begin
      slice_d = '0;
    end else if (load_i) begin
      slice_d = {valid_i, rfwe_i, sel_i, dm_i, alu_i, rtd_i};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slice_q <= '0;
    end else begin
      slice_q <= slice_d;
    end
  end

  assign {valid_o, rfwe_o, sel_o, dm_o, alu_o, rtd_o} = slice_q;
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM-to-WB pipeline of STAGES slices with stall, flush, result mux and youngest-first forwarding.
// Optional retire counter and RetireCnt port enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int STAGES = 1,
  parameter int CW     = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          ValidM,
  input  logic          RFWEM,
  input  logic          MtoRFSelM,
  input  logic [DW-1:0] RD,
  input  logic [DW-1:0] ALUOutM,
  input  logic [AW-1:0] rtdM,
  input  logic          STALL,
  input  logic          FLUSH,
  input  logic [AW-1:0] rsQ,
  input  logic [AW-1:0] rtQ,
  output logic          ValidW,
  output logic          RFWEW,
  output logic          MtoRFSelW,
  output logic [DW-1:0] DMOutW,
  output logic [DW-1:0] ALUOutW,
  output logic [DW-1:0] ResultW,
  output logic [AW-1:0] rtdW,
  output logic          FwdAHit,
  output logic [DW-1:0] FwdAData,
  output logic          FwdBHit,
  output logic [DW-1:0] FwdBData
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [CW-1:0] RetireCnt
`endif
);
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > STAGES_MAX || CW < 1) begin : g_bad_cfg
    $error("mem_wb_pipe: STAGES must be 1..%0d and CW >= 1", STAGES_MAX);
  end

  logic [STAGES-1:0] vld_q, rfwe_q, sel_q;
  logic [DW-1:0]     dm_q  [STAGES];
  logic [DW-1:0]     alu_q [STAGES];
  logic [DW-1:0]     res   [STAGES];
  logic [AW-1:0]     rtd_q [STAGES];

  // Slice 0 takes the bubble on flush; older slices always advance unless a pure stall holds them.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_head
      mem_wb_slice #(.DW(DW), .AW(AW)) u_slice (
        .CLK(CLK), .RSTn(RSTn), .load_i(!STALL), .bubble_i(FLUSH),
        .valid_i(ValidM), .rfwe_i(RFWEM), .sel_i(MtoRFSelM),
        .dm_i(RD), .alu_i(ALUOutM), .rtd_i(rtdM),
        .valid_o(vld_q[k]), .rfwe_o(rfwe_q[k]), .sel_o(sel_q[k]),
        .dm_o(dm_q[k]), .alu_o(alu_q[k]), .rtd_o(rtd_q[k])
      );
    end else begin : g_tail
      mem_wb_slice #(.DW(DW), .AW(AW)) u_slice (
        .CLK(CLK), .RSTn(RSTn), .load_i(FLUSH || !STALL), .bubble_i(1'b0),
        .valid_i(vld_q[k-1]), .rfwe_i(rfwe_q[k-1]), .sel_i(sel_q[k-1]),
        .dm_i(dm_q[k-1]), .alu_i(alu_q[k-1]), .rtd_i(rtd_q[k-1]),
        .valid_o(vld_q[k]), .rfwe_o(rfwe_q[k]), .sel_o(sel_q[k]),
        .dm_o(dm_q[k]), .alu_o(alu_q[k]), .rtd_o(rtd_q[k])
      );
    end
    assign res[k] = sel_q[k] ? dm_q[k] : alu_q[k];
  end

  assign ValidW    = vld_q[LAST];
  assign MtoRFSelW = sel_q[LAST];
  assign DMOutW    = dm_q[LAST];
  assign ALUOutW   = alu_q[LAST];
  assign ResultW   = res[LAST];
  assign rtdW      = rtd_q[LAST];
  assign RFWEW     = vld_q[LAST] & rfwe_q[LAST] & (rtd_q[LAST] != AW'(REG_ZERO));

  function automatic logic fwd_match(input logic vld, input logic we,
                                     input logic [AW-1:0] rtd, input logic [AW-1:0] q);
    return vld && we && (rtd == q) && (q != AW'(REG_ZERO));
  endfunction

  // Scan oldest to youngest so the lowest matching index is written last and wins.
  always_comb begin
    FwdAHit  = 1'b0;
    FwdAData = '0;
    FwdBHit  = 1'b0;
    FwdBData = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (fwd_match(vld_q[k], rfwe_q[k], rtd_q[k], rsQ)) begin
        FwdAHit  = 1'b1;
        FwdAData = res[k];
      end
      if (fwd_match(vld_q[k], rfwe_q[k], rtd_q[k], rtQ)) begin
        FwdBHit  = 1'b1;
        FwdBData = res[k];
      end
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CW-1:0] retire_d, retire_q;

  // The last slice is consumed whenever the pipe advances, including on flush.
  always_comb begin
    retire_d = retire_q;
    if (ValidW && (FLUSH || !STALL)) begin
      retire_d = retire_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign RetireCnt = retire_q;
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench: a 2-slice and a 3-slice instance share one stimulus stream.
module tb_mem_wb_pipe;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        ValidM, RFWEM, MtoRFSelM, STALL, FLUSH;
  logic [31:0] RD, ALUOutM;
  logic [4:0]  rtdM, rsQ, rtQ;

  logic        ValidW2, RFWEW2, MtoRFSelW2, FwdAHit2, FwdBHit2;
  logic [31:0] DMOutW2, ALUOutW2, ResultW2, FwdAData2, FwdBData2;
  logic [4:0]  rtdW2;
  logic        ValidW3, RFWEW3, MtoRFSelW3, FwdAHit3, FwdBHit3;
  logic [31:0] DMOutW3, ALUOutW3, ResultW3, FwdAData3, FwdBData3;
  logic [4:0]  rtdW3;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [3:0]  RetireCnt2, RetireCnt3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mem_wb_pipe #(.DW(32), .AW(5), .STAGES(2), .CW(4)) u2 (
    .CLK(CLK), .RSTn(RSTn), .ValidM(ValidM), .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM),
    .RD(RD), .ALUOutM(ALUOutM), .rtdM(rtdM), .STALL(STALL), .FLUSH(FLUSH),
    .rsQ(rsQ), .rtQ(rtQ), .ValidW(ValidW2), .RFWEW(RFWEW2), .MtoRFSelW(MtoRFSelW2),
    .DMOutW(DMOutW2), .ALUOutW(ALUOutW2), .ResultW(ResultW2), .rtdW(rtdW2),
    .FwdAHit(FwdAHit2), .FwdAData(FwdAData2), .FwdBHit(FwdBHit2), .FwdBData(FwdBData2)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .RetireCnt(RetireCnt2)
`endif
  );

  mem_wb_pipe #(.DW(32), .AW(5), .STAGES(3), .CW(4)) u3 (
    .CLK(CLK), .RSTn(RSTn), .ValidM(ValidM), .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM),
    .RD(RD), .ALUOutM(ALUOutM), .rtdM(rtdM), .STALL(STALL), .FLUSH(FLUSH),
    .rsQ(rsQ), .rtQ(rtQ), .ValidW(ValidW3), .RFWEW(RFWEW3), .MtoRFSelW(MtoRFSelW3),
    .DMOutW(DMOutW3), .ALUOutW(ALUOutW3), .ResultW(ResultW3), .rtdW(rtdW3),
    .FwdAHit(FwdAHit3), .FwdAData(FwdAData3), .FwdBHit(FwdBHit3), .FwdBData(FwdBData3)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .RetireCnt(RetireCnt3)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_m(input logic v, input logic we, input logic sel,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] rtd);
    ValidM = v; RFWEM = we; MtoRFSelM = sel; RD = rd; ALUOutM = alu; rtdM = rtd;
  endtask

  task automatic drain(input int n);
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    RSTn = 1'b0; STALL = 1'b0; FLUSH = 1'b0; rsQ = 5'd0; rtQ = 5'd0;
    set_m(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    step();
    n_cmp++; if (ValidW2 !== 1'b0) begin n_err++; $display("FAIL rst_valid2: got %b want 0", ValidW2); end
    n_cmp++; if (ResultW2 !== 32'h0) begin n_err++; $display("FAIL rst_result2: got %h want 0", ResultW2); end
    n_cmp++; if (rtdW3 !== 5'd0) begin n_err++; $display("FAIL rst_rtd3: got %0d want 0", rtdW3); end
    n_cmp++; if (RFWEW3 !== 1'b0) begin n_err++; $display("FAIL rst_rfwe3: got %b want 0", RFWEW3); end
    n_cmp++; if (DMOutW3 !== 32'h0) begin n_err++; $display("FAIL rst_dm3: got %h want 0", DMOutW3); end
`ifdef MEM_WB_RETIRE_CNT_EN
    n_cmp++; if (RetireCnt3 !== 4'd0) begin n_err++; $display("FAIL rst_cnt3: got %0d want 0", RetireCnt3); end
`endif
  endtask

  task automatic test_reset_midstream();
    RSTn = 1'b1;
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'hA1, 5'd1); step();
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'hA2, 5'd2); step();
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'hA3, 5'd3); step();
    rsQ = 5'd2; #1;
    n_cmp++; if (ValidW3 !== 1'b1 || ALUOutW3 !== 32'hA1) begin n_err++; $display("FAIL pre_rst_w3: got %b/%h want 1/000000a1", ValidW3, ALUOutW3); end
    n_cmp++; if (FwdAHit3 !== 1'b1) begin n_err++; $display("FAIL pre_rst_fwd3: got %b want 1", FwdAHit3); end
    RSTn = 1'b0; #1;
    n_cmp++; if (ValidW3 !== 1'b0) begin n_err++; $display("FAIL async_rst_valid3: got %b want 0", ValidW3); end
    n_cmp++; if (ALUOutW3 !== 32'h0) begin n_err++; $display("FAIL async_rst_alu3: got %h want 0", ALUOutW3); end
    n_cmp++; if (FwdAHit3 !== 1'b0 || FwdAData3 !== 32'h0) begin n_err++; $display("FAIL async_rst_fwd3: got %b/%h want 0/0", FwdAHit3, FwdAData3); end
    n_cmp++; if (ValidW2 !== 1'b0 || rtdW2 !== 5'd0) begin n_err++; $display("FAIL async_rst_w2: got %b/%0d want 0/0", ValidW2, rtdW2); end
    #1; RSTn = 1'b1; rsQ = 5'd0;
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd2);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    n_cmp++; if (ValidW2 !== 1'b0) begin n_err++; $display("FAIL lat_edge1_u2: got %b want 0", ValidW2); end
    step();
    n_cmp++; if (ValidW2 !== 1'b1 || ALUOutW2 !== 32'h77) begin n_err++; $display("FAIL lat_edge2_u2: got %b/%h want 1/00000077", ValidW2, ALUOutW2); end
    n_cmp++; if (ValidW3 !== 1'b0) begin n_err++; $display("FAIL lat_edge2_u3: got %b want 0", ValidW3); end
    step();
    n_cmp++; if (ValidW3 !== 1'b1 || ALUOutW3 !== 32'h77) begin n_err++; $display("FAIL lat_edge3_u3: got %b/%h want 1/00000077", ValidW3, ALUOutW3); end
  endtask

  task automatic test_passthrough();
    drain(3);
    set_m(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd7);
    step();
    set_m(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd0);
    step();
    set_m(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h4242, 5'd9);
    n_cmp++; if (ResultW2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pass_result: got %h want deadbeef", ResultW2); end
    n_cmp++; if (rtdW2 !== 5'd7) begin n_err++; $display("FAIL pass_rtd: got %0d want 7", rtdW2); end
    n_cmp++; if (RFWEW2 !== 1'b1) begin n_err++; $display("FAIL pass_rfwe: got %b want 1", RFWEW2); end
    n_cmp++; if (ALUOutW2 !== 32'h10 || MtoRFSelW2 !== 1'b1) begin n_err++; $display("FAIL pass_alu_sel: got %h/%b want 00000010/1", ALUOutW2, MtoRFSelW2); end
    step();
    n_cmp++; if (RFWEW2 !== 1'b0 || ValidW2 !== 1'b1) begin n_err++; $display("FAIL pass_r0_rfwe: got %b/%b want 0/1", RFWEW2, ValidW2); end
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    n_cmp++; if (ResultW2 !== 32'h4242 || DMOutW2 !== 32'h1234_5678) begin n_err++; $display("FAIL pass_alu_mux: got %h/%h want 00004242/12345678", ResultW2, DMOutW2); end
    n_cmp++; if (RFWEW2 !== 1'b1 || rtdW2 !== 5'd9) begin n_err++; $display("FAIL pass_alu_rfwe: got %b/%0d want 1/9", RFWEW2, rtdW2); end
  endtask

  task automatic test_stall();
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [3:0] cnt0;
`endif
    drain(3);
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd3);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    n_cmp++; if (ValidW2 !== 1'b1 || ResultW2 !== 32'h55) begin n_err++; $display("FAIL stall_pre: got %b/%h want 1/00000055", ValidW2, ResultW2); end
`ifdef MEM_WB_RETIRE_CNT_EN
    cnt0 = RetireCnt2;
`endif
    STALL = 1'b1;
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h99, 5'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (ValidW2 !== 1'b1 || ResultW2 !== 32'h55 || rtdW2 !== 5'd3) begin n_err++; $display("FAIL stall_hold[%0d]: got %b/%h/%0d want 1/00000055/3", i, ValidW2, ResultW2, rtdW2); end
      n_cmp++; if (RFWEW2 !== 1'b1) begin n_err++; $display("FAIL stall_rfwe[%0d]: got %b want 1", i, RFWEW2); end
`ifdef MEM_WB_RETIRE_CNT_EN
      n_cmp++; if (RetireCnt2 !== cnt0) begin n_err++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, RetireCnt2, cnt0); end
`endif
    end
    STALL = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    n_cmp++; if (ValidW2 !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", ValidW2); end
`ifdef MEM_WB_RETIRE_CNT_EN
    n_cmp++; if (RetireCnt2 !== cnt0 + 4'd1) begin n_err++; $display("FAIL stall_cnt_inc: got %0d want %0d", RetireCnt2, cnt0 + 4'd1); end
`endif
    step();
    n_cmp++; if (ValidW2 !== 1'b0) begin n_err++; $display("FAIL stall_no_leak: got %b want 0", ValidW2); end
  endtask

  task automatic test_flush();
    drain(3);
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 5'd4);
    step();
    FLUSH = 1'b1; STALL = 1'b1;
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd6);
    step();
    n_cmp++; if (ValidW2 !== 1'b1 || ALUOutW2 !== 32'h66 || rtdW2 !== 5'd4) begin n_err++; $display("FAIL flush_advance: got %b/%h/%0d want 1/00000066/4", ValidW2, ALUOutW2, rtdW2); end
    FLUSH = 1'b0; STALL = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    n_cmp++; if (ValidW2 !== 1'b0 || RFWEW2 !== 1'b0) begin n_err++; $display("FAIL flush_bubble: got %b/%b want 0/0", ValidW2, RFWEW2); end
    n_cmp++; if (ALUOutW2 !== 32'h0 || rtdW2 !== 5'd0) begin n_err++; $display("FAIL flush_bubble_zero: got %h/%0d want 0/0", ALUOutW2, rtdW2); end
  endtask

  task automatic test_forward();
    drain(3);
    set_m(1'b1, 1'b1, 1'b1, 32'h22, 32'hBAD, 5'd5); step();
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h33, 5'd9);   step();
    set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'h11, 5'd5);   step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rsQ = 5'd5; rtQ = 5'd9; #1;
    n_cmp++; if (FwdAHit3 !== 1'b1 || FwdAData3 !== 32'h11) begin n_err++; $display("FAIL fwd_youngest: got %b/%h want 1/00000011", FwdAHit3, FwdAData3); end
    n_cmp++; if (FwdBHit3 !== 1'b1 || FwdBData3 !== 32'h33) begin n_err++; $display("FAIL fwd_mid: got %b/%h want 1/00000033", FwdBHit3, FwdBData3); end
    n_cmp++; if (ResultW3 !== 32'h22 || RFWEW3 !== 1'b1) begin n_err++; $display("FAIL fwd_w3_result: got %h/%b want 00000022/1", ResultW3, RFWEW3); end
    rtQ = 5'd0; #1;
    n_cmp++; if (FwdBHit3 !== 1'b0 || FwdBData3 !== 32'h0) begin n_err++; $display("FAIL fwd_r0: got %b/%h want 0/0", FwdBHit3, FwdBData3); end
    rtQ = 5'd6; #1;
    n_cmp++; if (FwdBHit3 !== 1'b0) begin n_err++; $display("FAIL fwd_nomatch: got %b want 0", FwdBHit3); end
    drain(3);
    set_m(1'b1, 1'b1, 1'b1, 32'h22, 32'hBAD, 5'd5); step();
    set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h33, 5'd9);   step();
    set_m(1'b0, 1'b1, 1'b0, 32'h0, 32'h11, 5'd5);   step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rsQ = 5'd5; rtQ = 5'd9; #1;
    n_cmp++; if (FwdAHit3 !== 1'b1 || FwdAData3 !== 32'h22) begin n_err++; $display("FAIL fwd_skip_invalid: got %b/%h want 1/00000022", FwdAHit3, FwdAData3); end
    n_cmp++; if (FwdBHit3 !== 1'b0) begin n_err++; $display("FAIL fwd_skip_nowe: got %b want 0", FwdBHit3); end
    rsQ = 5'd0; rtQ = 5'd0;
  endtask

`ifdef MEM_WB_RETIRE_CNT_EN
  task automatic test_counter_wrap();
    #2; RSTn = 1'b0; #1; RSTn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_m(1'b1, 1'b1, 1'b0, 32'h0, 32'(i), 5'd1);
      step();
    end
    drain(3);
    n_cmp++; if (RetireCnt3 !== 4'd1) begin n_err++; $display("FAIL cnt_wrap3: got %0d want 1", RetireCnt3); end
    n_cmp++; if (RetireCnt2 !== 4'd1) begin n_err++; $display("FAIL cnt_wrap2: got %0d want 1", RetireCnt2); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midstream();
    test_passthrough();
    test_stall();
    test_flush();
    test_forward();
`ifdef MEM_WB_RETIRE_CNT_EN
    test_counter_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
